// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: FSM states, access sizes,
// the ByteSrcM bit that selects zero-extension, and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int ZEXT = 2;

    // Size code 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data extraction: shift the addressed lane down to bit 0, then sign- or
// zero-extend from 8, 16 or XLEN bits.
module load_extend import mem_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            zext,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SZ_BYTE: result = {{(XLEN-8){shifted[7] & ~zext}}, shifted[7:0]};
            SZ_HALF: result = {{(XLEN-16){shifted[15] & ~zext}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit: turns load/store instructions into a
// req/gnt/rvalid bus transaction and stalls the pipeline until it completes.
module mem_access_unit import mem_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [1:0]      ByteAccessM,
    input  logic [2:0]      ByteSrcM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            MisalignM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [1:0]      dbg_state
);

    state_e          state_q, state_d;
    logic [XLEN-3:0] addr_q, addr_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            zext_q, zext_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            access;
    logic            misaligned;
    logic [3:0]      store_be;
    logic [XLEN-1:0] store_wdata;
    logic [XLEN-1:0] load_result;
    logic            unused_bytesrc;

    assign unused_bytesrc = ^ByteSrcM[1:0];

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .size   (size_q),
        .zext   (zext_q),
        .result (load_result)
    );

    always_comb begin
        access     = MemReadM | MemWriteM;
        misaligned = access & is_misaligned(ByteAccessM, ALUResultM[1:0]);
        case (ByteAccessM)
            SZ_BYTE: begin
                store_be    = 4'b0001 << ALUResultM[1:0];
                store_wdata = {(XLEN/8){WriteDataM[7:0]}};
            end
            SZ_HALF: begin
                store_be    = 4'b0011 << ALUResultM[1:0];
                store_wdata = {(XLEN/16){WriteDataM[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = WriteDataM;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        zext_d  = zext_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (access && !misaligned) begin
                    // A set MemWriteM wins when both strobes are asserted.
                    addr_d  = ALUResultM[XLEN-1:2];
                    off_d   = ALUResultM[1:0];
                    size_d  = ByteAccessM;
                    zext_d  = ByteSrcM[ZEXT];
                    be_d    = MemWriteM ? store_be : 4'b1111;
                    wdata_d = store_wdata;
                    we_d    = MemWriteM;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    state_d = dmem_rvalid ? ST_DONE : ST_WAIT;
                    if (dmem_rvalid && !we_q) rdata_d = load_result;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_d = ST_DONE;
                    if (!we_q) rdata_d = load_result;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            zext_q  <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            zext_q  <= zext_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // The IDLE-cycle terms are gated by reset so every output reads 0 while it is held.
    assign StallM     = (reset & (state_q == ST_IDLE) & access & ~misaligned)
                      | (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign MisalignM  = reset & (state_q == ST_IDLE) & misaligned;
    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign ReadDataM  = rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized back-to-back
// loads/stores against an arithmetic model of the memory interface.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [1:0]  ByteAccessM;
    logic [2:0]  ByteSrcM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ByteAccessM(ByteAccessM), .ByteSrcM(ByteSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic wr, input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        if (!wr) return 4'hF;
        be = 4'h0;
        for (int i = 0; i < size_bytes(sz); i++) be[int'(off) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (size_bytes(sz) == 1) return {24'h0, wd[7:0]} * 32'h01010101;
        if (size_bytes(sz) == 2) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic zext,
                                               input logic [1:0] off, input logic [31:0] rd);
        int bits;
        logic [31:0] v;
        logic [31:0] mask;
        bits = 8 * size_bytes(sz);
        v = rd >> (8 * int'(off));
        if (bits == 32) return v;
        mask = (32'd1 << bits) - 32'd1;
        v = v & mask;
        if (!zext && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // driver tasks
    task automatic idle_inputs();
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteAccessM = 2'b00; ByteSrcM = 3'b000;
        ALUResultM = '0; WriteDataM = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic [2:0] src,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           output int stall_cnt, output int req_cnt,
                           output logic [31:0] o_addr, output logic [3:0] o_be,
                           output logic [31:0] o_wdata, output logic o_we,
                           output logic stable, output logic [31:0] o_rdm, output logic done_seen);
        int gnt_cyc;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ByteAccessM = sz; ByteSrcM = src;
        ALUResultM = addr; WriteDataM = wd;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        stall_cnt = 0; req_cnt = 0; stable = 1'b1; done_seen = 1'b0; gnt_cyc = -1;
        o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0; o_rdm = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (!StallM) begin
                done_seen = 1'b1;
                o_rdm = ReadDataM;
                break;
            end
            stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
                end else if (dmem_addr !== o_addr || dmem_be !== o_be ||
                             dmem_wdata !== o_wdata || dmem_we !== o_we) begin
                    stable = 1'b0;
                end
                if (req_cnt == gnt_dly + 1) begin
                    dmem_gnt = 1'b1;
                    gnt_cyc = cyc;
                end
            end
            if (gnt_cyc >= 0 && cyc == gnt_cyc + rv_dly) begin
                dmem_rvalid = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
        end
        if (!done_seen) begin
            n_vec++;
            n_err++;
            $display("FAIL txn_timeout: addr=%h no DONE cycle within 200 cycles", addr);
        end
    endtask

    // scenarios
    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL reset_rdm: got %h exp 0", ReadDataM); end
        n_vec++; if (StallM !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", StallM); end
        n_vec++; if (MisalignM !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b exp 0", MisalignM); end
        n_vec++; if ({dmem_req, dmem_we, dmem_be} !== 6'h0) begin n_err++; $display("FAIL reset_ctl: got req=%b we=%b be=%b exp 0", dmem_req, dmem_we, dmem_be); end
        n_vec++; if ({dmem_addr, dmem_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_bus: got addr=%h wdata=%h exp 0", dmem_addr, dmem_wdata); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lw();
        int st, rq; logic [31:0] a, wdo, rdm; logic [3:0] be; logic we, stb, dn;
        run_txn(1'b1, 1'b0, 2'b10, 3'b000, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF,
                st, rq, a, be, wdo, we, stb, rdm, dn);
        n_vec++; if (st != 3) begin n_err++; $display("FAIL lw_stall_cycles: got %0d exp 3", st); end
        n_vec++; if (rdm !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata: got %h exp deadbeef", rdm); end
        n_vec++; if (a !== 32'h100 || be !== 4'hF || we !== 1'b0) begin n_err++; $display("FAIL lw_req: got addr=%h be=%b we=%b exp 100/1111/0", a, be, we); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_vec++; if (ReadDataM !== 32'hDEADBEEF || dmem_req !== 1'b0) begin n_err++; $display("FAIL lw_hold: got rdm=%h req=%b exp deadbeef/0", ReadDataM, dmem_req); end
    endtask

    task automatic test_lb_lbu();
        int st, rq; logic [31:0] a, wdo, rdm, rd; logic [3:0] be; logic we, stb, dn;
        rd = {8'h80, 24'($urandom)};
        run_txn(1'b1, 1'b0, 2'b00, 3'b000, 32'h103, 32'h0, 0, 0, rd, st, rq, a, be, wdo, we, stb, rdm, dn);
        n_vec++; if (rdm !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_sext: got %h exp ffffff80", rdm); end
        n_vec++; if (st != 2) begin n_err++; $display("FAIL lb_min_stall: got %0d exp 2", st); end
        run_txn(1'b1, 1'b0, 2'b00, 3'b100, 32'h103, 32'h0, 0, 0, rd, st, rq, a, be, wdo, we, stb, rdm, dn);
        n_vec++; if (rdm !== 32'h00000080) begin n_err++; $display("FAIL lbu_zext: got %h exp 00000080", rdm); end
    endtask

    task automatic test_sh();
        int st, rq; logic [31:0] a, wdo, rdm; logic [3:0] be; logic we, stb, dn;
        run_txn(1'b0, 1'b1, 2'b01, 3'b000, 32'h102, {16'($urandom), 16'h1234}, 0, 1, 32'hFFFFFFFF,
                st, rq, a, be, wdo, we, stb, rdm, dn);
        n_vec++; if (be !== 4'b1100) begin n_err++; $display("FAIL sh_be: got %b exp 1100", be); end
        n_vec++; if (wdo !== 32'h12341234) begin n_err++; $display("FAIL sh_wdata: got %h exp 12341234", wdo); end
        n_vec++; if (we !== 1'b1 || a !== 32'h100) begin n_err++; $display("FAIL sh_we_addr: got we=%b addr=%h exp 1/100", we, a); end
        n_vec++; if (rdm !== 32'h00000080) begin n_err++; $display("FAIL sh_rdm_hold: got %h exp 00000080", rdm); end
    endtask

    task automatic test_gnt_stall();
        int st, rq; logic [31:0] a, wdo, rdm; logic [3:0] be; logic we, stb, dn;
        run_txn(1'b0, 1'b1, 2'b00, 3'b000, 32'h241, 32'h000000A5, 5, 2, 32'h0,
                st, rq, a, be, wdo, we, stb, rdm, dn);
        n_vec++; if (stb !== 1'b1) begin n_err++; $display("FAIL gnt_wait_stable: got %b exp 1", stb); end
        n_vec++; if (rq != 6) begin n_err++; $display("FAIL gnt_wait_req_cycles: got %0d exp 6", rq); end
        n_vec++; if (st != 9) begin n_err++; $display("FAIL gnt_wait_stall: got %0d exp 9", st); end
        n_vec++; if (be !== 4'b0010 || wdo !== 32'hA5A5A5A5) begin n_err++; $display("FAIL gnt_wait_sb: got be=%b wdata=%h exp 0010/a5a5a5a5", be, wdo); end
    endtask

    task automatic test_misalign();
        logic [1:0]  szs[3]   = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addrs[3] = '{32'h101, 32'h103, 32'h102};
        logic        wrs[3]   = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MemReadM = ~wrs[i]; MemWriteM = wrs[i]; ByteAccessM = szs[i]; ALUResultM = addrs[i];
            #1;
            n_vec++; if (MisalignM !== 1'b1 || StallM !== 1'b0 || dmem_req !== 1'b0) begin
                n_err++; $display("FAIL misalign_%0d: got mis=%b stall=%b req=%b exp 1/0/0", i, MisalignM, StallM, dmem_req); end
            @(negedge clk);
            idle_inputs();
            #1;
            n_vec++; if (dbg_state !== ST_IDLE || dmem_req !== 1'b0 || MisalignM !== 1'b0) begin
                n_err++; $display("FAIL misalign_after_%0d: got state=%0d req=%b mis=%b exp idle/0/0", i, dbg_state, dmem_req, MisalignM); end
        end
    endtask

    task automatic test_back_to_back();
        int st, rq, gd, rvd; logic [31:0] a, wdo, rdm, addr, wd, rd, last_load, exp_rdm;
        logic [3:0] be; logic we, stb, dn, isrd, iswr; logic [1:0] sz, off; logic [2:0] src;
        last_load = 32'h00000080;
        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin isrd = 1'b1; iswr = 1'b0; end
                1: begin isrd = 1'b0; iswr = 1'b1; end
                default: begin isrd = 1'b1; iswr = 1'b1; end
            endcase
            off = 2'($urandom_range(0, 3));
            if (size_bytes(sz) == 2) off[0] = 1'b0;
            if (size_bytes(sz) == 4) off = 2'b00;
            addr = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'(off);
            src = 3'($urandom);
            wd = $urandom; rd = $urandom;
            gd = $urandom_range(0, 3); rvd = $urandom_range(0, 3);
            if (!iswr) last_load = model_load(sz, src[2], off, rd);
            exp_q.push_back(last_load);
            run_txn(isrd, iswr, sz, src, addr, wd, gd, rvd, rd, st, rq, a, be, wdo, we, stb, rdm, dn);
            exp_rdm = exp_q.pop_front();
            n_vec++; if (rdm !== exp_rdm) begin n_err++; $display("FAIL rand_rdm[%0d]: got %h exp %h", t, rdm, exp_rdm); end
            n_vec++; if (st != 2 + gd + rvd) begin n_err++; $display("FAIL rand_stall[%0d]: got %0d exp %0d", t, st, 2 + gd + rvd); end
            n_vec++; if (a !== (addr & 32'hFFFF_FFFC) || we !== iswr || be !== model_be(iswr, sz, off)) begin
                n_err++; $display("FAIL rand_req[%0d]: got addr=%h we=%b be=%b exp %h/%b/%b", t, a, we, be,
                                  addr & 32'hFFFF_FFFC, iswr, model_be(iswr, sz, off)); end
            if (iswr) begin
                n_vec++; if (wdo !== model_wdata(sz, wd)) begin n_err++; $display("FAIL rand_wdata[%0d]: got %h exp %h", t, wdo, model_wdata(sz, wd)); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; ByteAccessM = 2'b10; ALUResultM = 32'h200;
        @(negedge clk);
        #1;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        n_vec++; if (dbg_state !== ST_WAIT || StallM !== 1'b1) begin n_err++; $display("FAIL rstmid_in_wait: got state=%0d stall=%b exp %0d/1", dbg_state, StallM, ST_WAIT); end
        reset = 1'b0;
        #1;
        n_vec++; if (dbg_state !== ST_IDLE || ReadDataM !== 32'h0 || StallM !== 1'b0) begin
            n_err++; $display("FAIL rstmid_abandon: got state=%0d rdm=%h stall=%b exp idle/0/0", dbg_state, ReadDataM, StallM); end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
            @(negedge clk);
            #1;
            n_vec++; if (dbg_state !== ST_IDLE || ReadDataM !== 32'h0 || StallM !== 1'b0 || dmem_req !== 1'b0) begin
                n_err++; $display("FAIL rstmid_stray_%0d: got state=%0d rdm=%h stall=%b req=%b exp idle/0/0/0", c, dbg_state, ReadDataM, StallM, dmem_req); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_gnt_stall();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: XLEN, default 32, data and address width.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 MemReadM  in  1  the M-stage instruction is a load.
REQ-005 MemWriteM  in  1  the M-stage instruction is a store.
REQ-006 ByteAccessM  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 ByteSrcM  in  3  load extension: bit2=1 zero-extend, bit2=0 sign-extend; bits[1:0] ignored.
REQ-008 ALUResultM  in  XLEN  byte address.
REQ-009 WriteDataM  in  XLEN  raw store data, right-justified.
REQ-010 ReadDataM  out  XLEN  extended load data, valid in the DONE cycle.
REQ-011 StallM  out  1  freezes the F-through-M pipeline.
REQ-012 MisalignM  out  1  one-cycle pulse on a misaligned access.
REQ-013 dmem_req, dmem_we  out  1 each  request strobe and write flag.
REQ-014 dmem_addr  out  XLEN  word-aligned address, bits[1:0]=00.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_wdata  out  XLEN  lane-replicated store data.
REQ-017 dmem_gnt, dmem_rvalid  in  1 each  grant and response-valid.
REQ-018 dmem_rdata  in  XLEN  response data.

Function
REQ-019 The unit SHALL use a four-state FSM: IDLE, REQ, WAIT, DONE.
REQ-020 Access = MemReadM|MemWriteM; if both are set, the access SHALL be treated as a store.
REQ-021 Misaligned = half with addr[0]=1, or word with addr[1:0]!=00.
REQ-022 IDLE, aligned access: register addr, be, wdata, we; go to REQ; StallM=1.
REQ-023 IDLE, misaligned access: no request; MisalignM=1 for one cycle; StallM=0; stay in IDLE.
REQ-024 IDLE, no access: StallM=0 and dmem_req=0.
REQ-025 REQ: dmem_req=1; addr, be, wdata and we SHALL be held stable until dmem_gnt=1; StallM=1.
REQ-026 REQ with gnt=1 and rvalid=0: go to WAIT; with gnt=1 and rvalid=1 in the same cycle: go directly to DONE.
REQ-027 WAIT: dmem_req=0; StallM=1; on rvalid go to DONE. Stores also complete on rvalid.
REQ-028 On rvalid for a load, the unit SHALL capture extended data into the ReadDataM register.
REQ-029 DONE: StallM=0 for exactly one cycle, then go to IDLE unconditionally so the next instruction is sampled once.
REQ-030 Minimum occupancy is 2 stall cycles plus 1 DONE cycle; there is no upper bound.
REQ-031 dmem_rvalid outside REQ/WAIT SHALL be ignored.
REQ-032 Store byte: be=0001<<addr[1:0], wdata={4{wd[7:0]}}.
REQ-033 Store half: be=0011<<addr[1:0], wdata={2{wd[15:0]}}.
REQ-034 Store word: be=1111, wdata=wd.
REQ-035 Load: shift rdata right by 8*addr[1:0], then sign- or zero-extend to 8/16/32 bits per ByteAccessM/ByteSrcM.
REQ-036 Load requests SHALL drive dmem_be=1111 and dmem_we=0.
REQ-037 ReadDataM SHALL hold its value until the next load completes.

Reset
REQ-038 On reset low: FSM to IDLE; all outputs and registers to 0, including ReadDataM, dmem_*, StallM and MisalignM.
REQ-039 Reset mid-transaction SHALL abandon the request without a pulse; later stray gnt/rvalid SHALL be ignored.

Structure
REQ-040 Package mem_pkg SHALL hold the FSM state enum, the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the ZEXT bit index.
REQ-041 A combinational sub-module load_extend (rdata, offset, size, zext -> result) SHALL perform the load extraction.

Verification
REQ-042 lw at 0x100, gnt same cycle, rvalid +1 cycle with 0xDEADBEEF -> StallM high 3 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-043 lb at 0x103 with rdata 0x80xxxxxx -> ReadDataM=0xFFFFFF80; lbu -> 0x00000080.
REQ-044 sh 0x1234 at 0x102 -> dmem_be=1100, dmem_wdata=0x12341234, dmem_we=1.
REQ-045 gnt withheld 5 cycles -> req, addr and be stable throughout; StallM high until the DONE cycle.
REQ-046 lw at 0x101 -> MisalignM pulse, no dmem_req, StallM=0.
REQ-047 Reset asserted in WAIT, then stray rvalid -> state IDLE, ReadDataM=0, no DONE cycle.
